// File: rtl/fft_fifo_frame_ctrl.sv
// Frame sequencer for the FFT sample FIFO: captures one frame of ADC samples, drains it to the FFT
// over valid/ready with a last marker, and handles overflow and abort/flush. Optional macro: FFT_FIFO_CTRL_DECIM_EN.
module fft_fifo_frame_ctrl #(
  parameter int DATA_W    = 32,
  parameter int DEPTH_W   = 10,
  parameter int FRAME_LEN = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              cont,
  input  logic              abort,
`ifdef FFT_FIFO_CTRL_DECIM_EN
  input  logic [7:0]        decim,
`endif
  input  logic              adc_valid,
  input  logic [DATA_W-1:0] adc_data,
  output logic              fifo_wr_en,
  output logic [DATA_W-1:0] fifo_wr_data,
  input  logic              fifo_wr_full,
  output logic              fifo_rd_en,
  input  logic [DATA_W-1:0] fifo_rd_data,
  input  logic              fifo_rd_empty,
  output logic              fft_tvalid,
  output logic [DATA_W-1:0] fft_tdata,
  output logic              fft_tlast,
  input  logic              fft_tready,
  output logic              busy,
  output logic              overflow,
  output logic [15:0]       frame_cnt
);

  localparam int CW = $clog2(FRAME_LEN + 1);
  localparam logic [CW-1:0] LEN  = CW'(FRAME_LEN);
  localparam logic [CW-1:0] LAST = CW'(FRAME_LEN - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FILL  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_FLUSH = 2'd3;

  if (FRAME_LEN < 2 || FRAME_LEN > (1 << DEPTH_W)) begin : g_frame_len_check
    $error("FRAME_LEN must lie in 2..2**DEPTH_W");
  end

  logic [1:0]        state, state_next;
  logic [CW-1:0]     wr_cnt, rd_left, tx_cnt;
  logic [DATA_W-1:0] skid0, skid1;
  logic [1:0]        occ, occ_after;
  logic              inflight;
  logic              overflow_reg;
  logic [15:0]       frame_cnt_reg;

  logic in_fill, in_drain, in_flush;
  logic phase_zero, eligible, pop, push, rd_drain;
  logic final_write, last_accept, start_ok, clear_frame, enter_drain;

  assign in_fill  = (state == S_FILL);
  assign in_drain = (state == S_DRAIN);
  assign in_flush = (state == S_FLUSH);

`ifdef FFT_FIFO_CTRL_DECIM_EN
  logic [7:0] phase, decim_reg;
  assign phase_zero = (phase == 8'd0);

  // Phase advances on every strobe seen in FILL, including ones dropped for a full FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase     <= 8'd0;
      decim_reg <= 8'd0;
    end else begin
      if (start_ok)
        decim_reg <= decim;
      if (clear_frame)
        phase <= 8'd0;
      else if (in_fill && adc_valid)
        phase <= (phase == decim_reg) ? 8'd0 : phase + 8'd1;
    end
  end
`else
  assign phase_zero = 1'b1;
`endif

  assign eligible     = adc_valid && phase_zero;
  assign fifo_wr_en   = in_fill && eligible && !fifo_wr_full;
  assign fifo_wr_data = fifo_wr_en ? adc_data : '0;

  assign fft_tvalid = in_drain && (occ != 2'd0);
  assign fft_tdata  = skid0;
  assign fft_tlast  = fft_tvalid && (tx_cnt == LAST);

  assign pop       = fft_tvalid && fft_tready;
  assign push      = in_drain && inflight;
  assign occ_after = occ - {1'b0, pop};
  // Reserve a slot for every outstanding read so back-pressure can never overrun the skid buffer.
  assign rd_drain  = in_drain && !fifo_rd_empty && (rd_left != '0) &&
                     ((occ_after + {1'b0, inflight}) <= 2'd1);
  assign fifo_rd_en = rd_drain || (in_flush && !fifo_rd_empty);

  assign final_write = fifo_wr_en && (wr_cnt == LAST);
  assign last_accept = pop && (tx_cnt == LAST);
  assign start_ok    = (state == S_IDLE) && start && !abort;
  assign clear_frame = (state_next == S_FILL) && (state != S_FILL);
  assign enter_drain = (state_next == S_DRAIN) && (state != S_DRAIN);

  assign busy      = (state != S_IDLE);
  assign overflow  = overflow_reg;
  assign frame_cnt = frame_cnt_reg;

  always_comb begin
    state_next = state;
    if (abort) begin
      state_next = S_FLUSH;
    end else begin
      case (state)
        S_IDLE:  if (start) state_next = S_FILL;
        S_FILL:  if (final_write) state_next = S_DRAIN;
        S_DRAIN: if (last_accept) state_next = cont ? S_FILL : S_IDLE;
        S_FLUSH: if (fifo_rd_empty && !inflight) state_next = S_IDLE;
        default: state_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      wr_cnt        <= '0;
      rd_left       <= '0;
      tx_cnt        <= '0;
      inflight      <= 1'b0;
      overflow_reg  <= 1'b0;
      frame_cnt_reg <= 16'd0;
    end else begin
      state    <= state_next;
      inflight <= fifo_rd_en;

      if (clear_frame)
        wr_cnt <= '0;
      else if (fifo_wr_en)
        wr_cnt <= wr_cnt + CW'(1);

      if (enter_drain)
        rd_left <= LEN;
      else if (rd_drain)
        rd_left <= rd_left - CW'(1);

      if (enter_drain)
        tx_cnt <= '0;
      else if (pop)
        tx_cnt <= tx_cnt + CW'(1);

      if (start_ok)
        overflow_reg <= 1'b0;
      else if (in_fill && eligible && fifo_wr_full)
        overflow_reg <= 1'b1;

      if (last_accept && !abort)
        frame_cnt_reg <= frame_cnt_reg + 16'd1;
    end
  end

  // Head word always sits in skid0; anything not bound for DRAIN next cycle is discarded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ   <= 2'd0;
      skid0 <= '0;
      skid1 <= '0;
    end else if (state_next != S_DRAIN) begin
      occ <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (occ == 2'd0) skid0 <= fifo_rd_data;
          else             skid1 <= fifo_rd_data;
          occ <= occ + 2'd1;
        end
        2'b01: begin
          skid0 <= skid1;
          occ   <= occ - 2'd1;
        end
        2'b11: begin
          if (occ == 2'd1) begin
            skid0 <= fifo_rd_data;
          end else begin
            skid0 <= skid1;
            skid1 <= fifo_rd_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fft_fifo_frame_ctrl.sv
// Scoreboard bench for fft_fifo_frame_ctrl with FRAME_LEN=8 and a behavioural 16-deep synchronous FIFO.
module tb_fft_fifo_frame_ctrl;
  localparam int FL = 8;
  localparam int DW = 32;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          l;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0, cont = 1'b0, abort = 1'b0;
  logic adc_valid = 1'b0;
  logic [DW-1:0] adc_data = '0;
  logic fifo_wr_en, fifo_rd_en, fifo_wr_full, fifo_rd_empty;
  logic [DW-1:0] fifo_wr_data, fft_tdata;
  logic [DW-1:0] fifo_rd_data;
  logic fft_tvalid, fft_tlast;
  logic fft_tready = 1'b1;
  logic busy, overflow;
  logic [15:0] frame_cnt;
  logic [7:0] decim = 8'd0;

  int n_checks = 0;
  int n_fail = 0;
  exp_t exp_q[$];
  int dec = 0;
  int exp_frames = 0;
  int ready_mode = 0;
  bit no_valid = 1'b0;
  bit busy_watch = 1'b0;
  bit force_full = 1'b0;
  bit flush_count_en = 1'b0;

  always #5 clk = ~clk;

  fft_fifo_frame_ctrl #(.DATA_W(DW), .DEPTH_W(4), .FRAME_LEN(FL)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cont(cont), .abort(abort),
`ifdef FFT_FIFO_CTRL_DECIM_EN
    .decim(decim),
`endif
    .adc_valid(adc_valid), .adc_data(adc_data),
    .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data), .fifo_wr_full(fifo_wr_full),
    .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data), .fifo_rd_empty(fifo_rd_empty),
    .fft_tvalid(fft_tvalid), .fft_tdata(fft_tdata), .fft_tlast(fft_tlast), .fft_tready(fft_tready),
    .busy(busy), .overflow(overflow), .frame_cnt(frame_cnt)
  );

  // Behavioural synchronous FIFO, no output register: rd_data valid the cycle after rd_en.
  logic [DW-1:0] fmem [16];
  logic [4:0] fcnt;
  logic [3:0] fwp, frp;
  logic do_wr, do_rd;
  int rd_issue_cnt, acc_cnt, flush_reads;
  assign fifo_rd_empty = (fcnt == 5'd0);
  assign fifo_wr_full  = (fcnt == 5'd16) || force_full;
  assign do_wr = fifo_wr_en && !fifo_wr_full;
  assign do_rd = fifo_rd_en && !fifo_rd_empty;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fcnt <= '0; fwp <= '0; frp <= '0; fifo_rd_data <= '0;
      rd_issue_cnt <= 0; acc_cnt <= 0; flush_reads <= 0;
    end else begin
      if (do_rd) begin
        fifo_rd_data <= fmem[frp];
        frp <= frp + 4'd1;
      end
      if (do_wr) begin
        fmem[fwp] <= fifo_wr_data;
        fwp <= fwp + 4'd1;
      end
      fcnt <= fcnt + 5'(do_wr) - 5'(do_rd);
      if (do_rd && flush_count_en) flush_reads <= flush_reads + 1;
      if (do_rd && !flush_count_en) rd_issue_cnt <= rd_issue_cnt + 1;
      if (fft_tvalid && fft_tready) acc_cnt <= acc_cnt + 1;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every accepted word and checks stall stability.
  bit stall_prev = 1'b0;
  logic [DW-1:0] held_d;
  logic held_l;
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (no_valid) chk("tvalid_during_flush", {63'd0, fft_tvalid}, 64'd0);
      else chk("skid_occupancy_le2", {63'd0, (rd_issue_cnt - acc_cnt) <= 2}, 64'd1);
      if (busy_watch && cont) chk("busy_in_cont", {63'd0, busy}, 64'd1);
      if (stall_prev) begin
        chk("stall_valid_held", {63'd0, fft_tvalid}, 64'd1);
        chk("stall_data_stable", {31'd0, fft_tdata, fft_tlast}, {31'd0, held_d, held_l});
      end
      if (fft_tvalid && fft_tready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_word", {31'd0, fft_tdata, fft_tlast}, 64'd0);
        end else begin
          e = exp_q.pop_front();
          chk("tdata", {32'd0, fft_tdata}, {32'd0, e.d});
          chk("tlast", {63'd0, fft_tlast}, {63'd0, e.l});
          $display("word data=%08h last=%0d", fft_tdata, fft_tlast);
        end
      end
      stall_prev = fft_tvalid && !fft_tready;
      held_d = fft_tdata;
      held_l = fft_tlast;
    end
  end

  initial begin
    int p = 0;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0: fft_tready = 1'b1;
        1: begin
          case (p % 4)
            0, 3: fft_tready = 1'b1;
            default: fft_tready = 1'b0;
          endcase
          p++;
        end
        default: fft_tready = ($urandom_range(0, 2) != 0);
      endcase
    end
  end

  task automatic do_start();
    @(posedge clk); #1;
    decim = 8'(dec);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Reference: every (dec+1)-th strobe of the frame is eligible; eligible samples seen while full are lost.
  task automatic send_samples(input int n_acc, input int n_drop, input bit dense);
    int acc = 0;
    int k = 0;
    int drops = n_drop;
    bit v, elig;
    exp_t e;
    while (acc < n_acc) begin
      @(posedge clk); #1;
      v = dense ? 1'b1 : ($urandom_range(0, 3) != 0);
      adc_valid = v;
      adc_data = $urandom;
      elig = v && ((k % (dec + 1)) == 0);
      if (v) k++;
      force_full = elig && (drops > 0) && (acc >= 3);
      if (force_full) begin
        drops--;
      end else if (elig) begin
        e.d = adc_data;
        e.l = (acc == FL - 1);
        exp_q.push_back(e);
        acc++;
      end
    end
    @(posedge clk); #1;
    adc_valid = 1'b0;
    force_full = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    bit done = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) chk(tag, 64'd0, 64'd1);
    @(negedge clk);
    exp_frames++;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    adc_data = $urandom;
    chk("rst_wr_en", {63'd0, fifo_wr_en}, 64'd0);
    chk("rst_wr_data", {32'd0, fifo_wr_data}, 64'd0);
    chk("rst_rd_en", {63'd0, fifo_rd_en}, 64'd0);
    chk("rst_tvalid", {63'd0, fft_tvalid}, 64'd0);
    chk("rst_tlast", {63'd0, fft_tlast}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_overflow", {63'd0, overflow}, 64'd0);
    chk("rst_frame_cnt", {48'd0, frame_cnt}, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Basic frame: dense samples, tready always high.
    ready_mode = 0;
    do_start();
    send_samples(FL, 0, 1'b1);
    wait_done("t1_timeout");
    chk("t1_frame_cnt", {48'd0, frame_cnt}, 64'(exp_frames));
    chk("t1_busy_low", {63'd0, busy}, 64'd0);

    // Back-pressure pattern 1,0,0,1 with sparse random strobes.
    ready_mode = 1;
    do_start();
    send_samples(FL, 0, 1'b0);
    wait_done("t2_timeout");
    chk("t2_frame_cnt", {48'd0, frame_cnt}, 64'(exp_frames));

    // Overflow: three eligible samples hit a full FIFO.
    ready_mode = 2;
    do_start();
    send_samples(FL, 3, 1'b0);
    chk("t3_overflow_set", {63'd0, overflow}, 64'd1);
    wait_done("t3_timeout");
    chk("t3_frame_cnt", {48'd0, frame_cnt}, 64'(exp_frames));
    chk("t3_overflow_sticky", {63'd0, overflow}, 64'd1);

    // Continuous mode over three frames; start also clears overflow.
    do_start();
    cont = 1'b1;
    busy_watch = 1'b1;
    chk("t4_overflow_cleared", {63'd0, overflow}, 64'd0);
    for (int f = 0; f < 3; f++) begin
      send_samples(FL, 0, 1'b0);
      if (f == 2) cont = 1'b0;
      wait_done("t4_timeout");
    end
    busy_watch = 1'b0;
    chk("t4_frame_cnt", {48'd0, frame_cnt}, 64'(exp_frames));
    chk("t4_idle_after", {63'd0, busy}, 64'd0);

    // Abort after five writes: flush reads them all and produces no output.
    ready_mode = 0;
    do_start();
    send_samples(5, 0, 1'b1);
    exp_q.delete();
    no_valid = 1'b1;
    flush_count_en = 1'b1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    begin
      bit idle = 1'b0;
      for (int i = 0; i < 100; i++) begin
        @(negedge clk);
        if (!busy) begin
          idle = 1'b1;
          break;
        end
      end
      chk("t5_returns_idle", {63'd0, idle}, 64'd1);
    end
    chk("t5_flush_reads", 64'(flush_reads), 64'd5);
    chk("t5_fifo_empty", {59'd0, fcnt}, 64'd0);
    chk("t5_frame_cnt", {48'd0, frame_cnt}, 64'(exp_frames));
    no_valid = 1'b0;
    flush_count_en = 1'b0;

`ifdef FFT_FIFO_CTRL_DECIM_EN
    // Decimation by 3: strobes 0,3,...,21 are the frame.
    dec = 2;
    do_start();
    send_samples(FL, 0, 1'b1);
    wait_done("t6_timeout");
    chk("t6_frame_cnt", {48'd0, frame_cnt}, 64'(exp_frames));
    dec = 0;
`endif

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
